// File: rtl/king_pkg.sv
// Shared definitions for the KingProcessador multi-cycle sequencer: state codes,
// instruction class encoding and the decoded-flag priority resolver.
package king_pkg;

  localparam int unsigned STATE_W             = 3;
  localparam int unsigned CLASS_W             = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_WAIT_IN = 3'd5,
    ST_WRITE   = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU    = 3'd0,
    CLS_HALT   = 3'd1,
    CLS_IN     = 3'd2,
    CLS_OUT    = 3'd3,
    CLS_LOAD   = 3'd4,
    CLS_STORE  = 3'd5,
    CLS_BRANCH = 3'd6
  } class_e;

  typedef struct packed {
    logic halt;
    logic in;
    logic out;
    logic load;
    logic store;
    logic branch;
  } op_flags_t;

  // Highest-priority flag wins; lower ones are dropped.
  function automatic class_e classify(input op_flags_t f);
    if (f.halt)   return CLS_HALT;
    if (f.in)     return CLS_IN;
    if (f.out)    return CLS_OUT;
    if (f.load)   return CLS_LOAD;
    if (f.store)  return CLS_STORE;
    if (f.branch) return CLS_BRANCH;
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/debounce_confirma.sv
// Operator confirm button conditioning: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on each accepted rising edge.
module debounce_confirma
  import king_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // Count consecutive cycles the synchronized input disagrees with the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WRITE sequencer for the KingProcessador datapath,
// gating PC, IR, register-file, RAM and display strobes and stalling on operator input.
module sequenciador_multiciclo
  import king_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               op_halt,
  input  logic               op_in,
  input  logic               op_out,
  input  logic               op_load,
  input  logic               op_store,
  input  logic               op_branch,
  input  logic               confirma,
  output logic               ir_en,
  output logic               mem_we,
  output logic               reg_we,
  output logic               in_sel,
  output logic               out_en,
  output logic               pc_en,
  output logic               in_wait,
  output logic               halted,
  output logic [STATE_W-1:0] estado,
  output logic [CNT_W-1:0]   retired
);

  state_e           state_q, state_d;
  class_e           cls_q, cls_d;
  op_flags_t        flags;
  logic             btn_level, btn_rise;
  logic             ir_en_q, ir_en_d;
  logic             mem_we_q, mem_we_d;
  logic             reg_we_q, reg_we_d;
  logic             in_sel_q, in_sel_d;
  logic             out_en_q, out_en_d;
  logic             pc_en_q, pc_en_d;
  logic             in_wait_q, in_wait_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  assign flags = '{halt: op_halt, in: op_in, out: op_out,
                   load: op_load, store: op_store, branch: op_branch};

  debounce_confirma #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (confirma),
    .level_o(btn_level),
    .rise_o (btn_rise)
  );

  // Next state plus strobes decoded from the upcoming state, so every output is a flop.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    retired_d = retired_q;

    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d   = classify(flags);
        state_d = (cls_d == CLS_HALT) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_IN:              state_d = ST_WAIT_IN;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WRITE;
        endcase
      end
      ST_MEM:     state_d = ST_WRITE;
      ST_WAIT_IN: if (btn_rise && btn_level) state_d = ST_WRITE;
      ST_WRITE:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase

    ir_en_d   = (state_d == ST_FETCH);
    mem_we_d  = (state_d == ST_MEM) && (cls_d == CLS_STORE);
    reg_we_d  = (state_d == ST_WRITE) && (cls_d inside {CLS_ALU, CLS_LOAD, CLS_IN});
    in_sel_d  = (state_d == ST_WRITE) && (cls_d == CLS_IN);
    out_en_d  = (state_d == ST_WRITE) && (cls_d == CLS_OUT);
    pc_en_d   = (state_d == ST_WRITE);
    in_wait_d = (state_d == ST_WAIT_IN);
    halted_d  = (state_d == ST_HALT);

    if (pc_en_q) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_ALU;
      ir_en_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      in_sel_q  <= 1'b0;
      out_en_q  <= 1'b0;
      pc_en_q   <= 1'b0;
      in_wait_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      ir_en_q   <= ir_en_d;
      mem_we_q  <= mem_we_d;
      reg_we_q  <= reg_we_d;
      in_sel_q  <= in_sel_d;
      out_en_q  <= out_en_d;
      pc_en_q   <= pc_en_d;
      in_wait_q <= in_wait_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign ir_en   = ir_en_q;
  assign mem_we  = mem_we_q;
  assign reg_we  = reg_we_q;
  assign in_sel  = in_sel_q;
  assign out_en  = out_en_q;
  assign pc_en   = pc_en_q;
  assign in_wait = in_wait_q;
  assign halted  = halted_q;
  assign estado  = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Bench for sequenciador_multiciclo: instruction-plan reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized stimulus.
module tb_sequenciador_multiciclo;

  localparam int unsigned DEB = 16;
  localparam int unsigned CW  = 8;

  localparam int C_ALU = 0, C_HALT = 1, C_IN = 2, C_OUT = 3, C_LOAD = 4, C_STORE = 5, C_BR = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic op_halt = 1'b0, op_in = 1'b0, op_out = 1'b0;
  logic op_load = 1'b0, op_store = 1'b0, op_branch = 1'b0;
  logic confirma = 1'b0;
  logic ir_en, mem_we, reg_we, in_sel, out_en, pc_en, in_wait, halted;
  logic [2:0]    estado;
  logic [CW-1:0] retired;

  sequenciador_multiciclo #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .run      (run),
    .op_halt  (op_halt),
    .op_in    (op_in),
    .op_out   (op_out),
    .op_load  (op_load),
    .op_store (op_store),
    .op_branch(op_branch),
    .confirma (confirma),
    .ir_en    (ir_en),
    .mem_we   (mem_we),
    .reg_we   (reg_we),
    .in_sel   (in_sel),
    .out_en   (out_en),
    .pc_en    (pc_en),
    .in_wait  (in_wait),
    .halted   (halted),
    .estado   (estado),
    .retired  (retired)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each instruction is a plan of state codes; the debouncer is a
  // window over the last DEB synchronized samples.
  int   m_code = 0;
  int   m_cls  = 0;
  int   m_ret  = 0;
  int   plan[$];
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_rise = 1'b0;
  logic hist[DEB];

  always @(posedge clock) begin : model
    logic acc, all_diff;
    if (!reset) begin
      m_code = 0; m_cls = C_ALU; m_ret = 0; plan.delete();
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_rise = 1'b0;
      for (int i = 0; i < DEB; i++) hist[i] = 1'b0;
    end else begin
      acc = m_rise && (m_code == 5);
      if (m_code == 6) m_ret = (m_ret + 1) % (1 << CW);
      if (m_code == 7) begin
        m_code = 7;
      end else if (m_code == 2) begin
        if (op_halt)        m_cls = C_HALT;
        else if (op_in)     m_cls = C_IN;
        else if (op_out)    m_cls = C_OUT;
        else if (op_load)   m_cls = C_LOAD;
        else if (op_store)  m_cls = C_STORE;
        else if (op_branch) m_cls = C_BR;
        else                m_cls = C_ALU;
        plan.delete();
        if (m_cls == C_HALT) m_code = 7;
        else begin
          m_code = 3;
          if (m_cls == C_IN) plan.push_back(5);
          else if (m_cls == C_LOAD || m_cls == C_STORE) begin
            plan.push_back(4); plan.push_back(6);
          end else plan.push_back(6);
        end
      end else if (m_code == 5) begin
        m_code = acc ? 6 : 5;
      end else if (plan.size() > 0) begin
        m_code = plan.pop_front();
      end else if (run) begin
        m_code = 1; plan.push_back(2);
      end else begin
        m_code = 0;
      end
      for (int i = 0; i < DEB - 1; i++) hist[i] = hist[i+1];
      hist[DEB-1] = m_s2;
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) begin
        m_lvl  = ~m_lvl;
        m_rise = m_lvl;
      end else begin
        m_rise = 1'b0;
      end
      m_s2 = m_s1;
      m_s1 = confirma;
    end
  end

  always @(negedge clock) begin : compare
    logic wr;
    wr = (m_code == 6);
    cmp("estado",  32'(estado),  32'(m_code));
    cmp("ir_en",   32'(ir_en),   32'(m_code == 1));
    cmp("mem_we",  32'(mem_we),  32'(m_code == 4 && m_cls == C_STORE));
    cmp("reg_we",  32'(reg_we),  32'(wr && (m_cls == C_ALU || m_cls == C_LOAD || m_cls == C_IN)));
    cmp("in_sel",  32'(in_sel),  32'(wr && m_cls == C_IN));
    cmp("out_en",  32'(out_en),  32'(wr && m_cls == C_OUT));
    cmp("pc_en",   32'(pc_en),   32'(wr));
    cmp("in_wait", 32'(in_wait), 32'(m_code == 5));
    cmp("halted",  32'(halted),  32'(m_code == 7));
    cmp("retired", 32'(retired), 32'(m_ret));
  end

  int k = 0;
  int n_pc = 0, n_rw = 0, n_mw = 0;

  task automatic step();
    @(negedge clock);
    k++;
    n_pc += int'(pc_en);
    n_rw += int'(reg_we);
    n_mw += int'(mem_we);
  endtask

  task automatic set_ops(input logic h, input logic i, input logic o,
                         input logic l, input logic s, input logic b);
    op_halt = h; op_in = i; op_out = o; op_load = l; op_store = s; op_branch = b;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    cmp("rst_estado", 32'(estado), 32'd0);
    cmp("rst_retired", 32'(retired), 32'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    k = 0; n_pc = 0; n_rw = 0; n_mw = 0;
  endtask

  initial begin : stim
    int hold;
    // Three ALU instructions, run dropped during the third EXEC.
    set_ops(0, 0, 0, 0, 0, 0); run = 1'b1;
    reset_dut();
    repeat (16) begin
      step();
      if (k <= 4) cmp("alu_seq", 32'(estado), (k == 4) ? 32'd6 : 32'(k));
      if (k == 11) #1 run = 1'b0;
    end
    cmp("alu_pc_cnt", 32'(n_pc), 32'd3);
    cmp("alu_rw_cnt", 32'(n_rw), 32'd3);
    cmp("alu_retired", 32'(retired), 32'd3);
    cmp("alu_idle", 32'(estado), 32'd0);

    // Store then load.
    set_ops(0, 0, 0, 0, 1, 0); run = 1'b1;
    reset_dut();
    repeat (14) begin
      step();
      if (k == 3) #1 set_ops(0, 0, 0, 1, 0, 0);
      if (k == 8) #1 run = 1'b0;
      if (k == 4) cmp("st_mem_we", 32'(mem_we), 32'd1);
      if (k == 9) cmp("ld_mem_state", 32'(estado), 32'd4);
      if (k == 10) cmp("ld_reg_we", 32'(reg_we), 32'd1);
    end
    cmp("stld_mw_cnt", 32'(n_mw), 32'd1);
    cmp("stld_retired", 32'(retired), 32'd2);

    // Input instruction, press 40 cycles into WAIT_IN.
    set_ops(0, 1, 0, 0, 0, 0); run = 1'b1; confirma = 1'b0;
    reset_dut();
    repeat (70) begin
      step();
      if (k == 3) #1 run = 1'b0;
      if (k == 44) #1 confirma = 1'b1;
      if (k == 66) #1 confirma = 1'b0;
      if (k == 62) cmp("in_wait_pre", 32'(in_wait), 32'd1);
      if (k == 63) begin
        cmp("in_write", 32'(estado), 32'd6);
        cmp("in_sel", 32'(in_sel), 32'd1);
        cmp("in_reg_we", 32'(reg_we), 32'd1);
      end
    end
    cmp("in_retired", 32'(retired), 32'd1);

    // Button already held when WAIT_IN is entered.
    set_ops(0, 1, 0, 0, 0, 0); run = 1'b0; confirma = 1'b1;
    reset_dut();
    repeat (170) begin
      step();
      if (k == 30) #1 run = 1'b1;
      if (k == 32) #1 run = 1'b0;
      if (k == 90) #1 confirma = 1'b0;
      if (k == 130) #1 confirma = 1'b1;
      if (k == 160) #1 confirma = 1'b0;
      if (k == 80) cmp("held_no_accept", 32'(in_wait), 32'd1);
      if (k == 148) cmp("held_still_wait", 32'(estado), 32'd5);
      if (k == 149) cmp("held_write", 32'(estado), 32'd6);
    end
    cmp("held_retired", 32'(retired), 32'd1);

    // Halt with input also flagged; run toggling ignored.
    set_ops(1, 1, 0, 0, 0, 0); run = 1'b1;
    reset_dut();
    repeat (110) begin
      step();
      if (k == 3) cmp("halt_state", 32'(estado), 32'd7);
      if (k > 3) #1 run = 1'($urandom_range(0, 1));
    end
    cmp("halt_pc_cnt", 32'(n_pc), 32'd0);
    cmp("halted", 32'(halted), 32'd1);
    run = 1'b0;
    reset_dut();
    step();
    cmp("halt_reset_idle", 32'(estado), 32'd0);

    // Reset pulsed during MEM of a store.
    set_ops(0, 0, 0, 0, 1, 0); run = 1'b1;
    reset_dut();
    repeat (4) step();
    #1 reset = 1'b0; run = 1'b0;
    step();
    cmp("abort_outs", 32'({ir_en, mem_we, reg_we, in_sel, out_en, pc_en, in_wait, halted}), 32'd0);
    cmp("abort_estado", 32'(estado), 32'd0);
    #1 reset = 1'b1; n_mw = 0;
    repeat (20) step();
    cmp("abort_no_mw", 32'(n_mw), 32'd0);
    cmp("abort_retired", 32'(retired), 32'd0);

    // Counter wrap: 2^CW ALU instructions.
    set_ops(0, 0, 0, 0, 0, 0); run = 1'b1;
    reset_dut();
    repeat (1030) begin
      step();
      if (k == 1021) cmp("wrap_pre", 32'(retired), 32'd255);
      if (k == 1022) #1 run = 1'b0;
    end
    cmp("wrap_zero", 32'(retired), 32'd0);

    // Randomized traffic with periodic resets.
    confirma = 1'b0; hold = 5;
    reset_dut();
    for (int i = 0; i < 4000; i++) begin
      step();
      #1;
      run       = ($urandom_range(0, 9) != 0);
      op_halt   = ($urandom_range(0, 59) == 0);
      op_in     = ($urandom_range(0, 3) == 0);
      op_out    = ($urandom_range(0, 3) == 0);
      op_load   = ($urandom_range(0, 3) == 0);
      op_store  = ($urandom_range(0, 3) == 0);
      op_branch = ($urandom_range(0, 3) == 0);
      if (hold == 0) begin
        confirma = ~confirma;
        hold = $urandom_range(1, 40);
      end else begin
        hold--;
      end
      if (i % 400 == 399) reset_dut();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
